hp_reg3_fifo_m: RTL and testbench

HP_REG3_FIFO_M -- requirements
Module: hp_reg3_fifo_m

---
 rtl/hp_reg3_fifo_m.sv | 65 ++++++
 tb/tb_hp_reg3_fifo_m.sv | 125 ++++++++++++
 2 files changed

// File: rtl/hp_reg3_fifo_m.sv
// hp_reg3_fifo_m: 1-byte register / 2-byte FIFO with sticky error flags and NMI request
module hp_reg3_fifo_m (
  input  logic       p2_clk,
  input  logic       rst,
  input  logic       two_byte,
  input  logic       nmi_en,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       data_available,
  output logic       not_full,
  output logic [1:0] count,
  output logic       nmi_req,
  output logic       overflow,
  output logic       underflow
);
  logic       mode_q;
  logic [7:0] mem_q [2];
  logic       wp_q, rp_q;
  logic [1:0] count_q, count_d, cap;
  logic [7:0] rd_data_q;
  logic       nmi_q, ovf_q, unf_q;
  logic       flush, wr_ok, rd_ok;
  // decode capacity from the registered mode; a mode mismatch flushes and blocks strobes
  always_comb begin
    cap     = mode_q ? 2'd2 : 2'd1;
    flush   = mode_q != two_byte;
    wr_ok   = wr_en && count_q < cap && !flush;
    rd_ok   = rd_en && count_q != 2'd0 && !flush;
    count_d = flush ? 2'd0 : count_q + {1'b0, wr_ok} - {1'b0, rd_ok};
  end
  // storage array needs no reset: count gates what can be read back
  always_ff @(posedge p2_clk)
    if (!rst && wr_ok) mem_q[wp_q] <= wr_data;
  // pointers, occupancy, read register, sticky flags and NMI request
  always_ff @(posedge p2_clk) begin
    if (rst) begin
      mode_q    <= two_byte;
      count_q   <= 2'd0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      rd_data_q <= 8'h00;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      nmi_q     <= 1'b0;
    end else begin
      mode_q  <= two_byte;
      count_q <= count_d;
      wp_q    <= flush ? 1'b0 : wp_q ^ wr_ok;
      rp_q    <= flush ? 1'b0 : rp_q ^ rd_ok;
      if (rd_ok) rd_data_q <= mem_q[rp_q];
      ovf_q   <= ovf_q | (wr_en && !flush && !wr_ok);
      unf_q   <= unf_q | (rd_en && !flush && !rd_ok);
      nmi_q   <= nmi_en && count_d == cap;
    end
  end
  assign rd_data        = rd_data_q;
  assign count          = count_q;
  assign not_full       = count_q < cap;
  assign data_available = count_q == cap;
  assign nmi_req        = nmi_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;
endmodule

// File: tb/tb_hp_reg3_fifo_m.sv
// tb_hp_reg3_fifo_m: directed self-checking bench for hp_reg3_fifo_m
module tb_hp_reg3_fifo_m;
  logic       p2_clk = 1'b0;
  logic       rst = 1'b1, two_byte = 1'b0, nmi_en = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       data_available, not_full, nmi_req, overflow, underflow;
  logic [1:0] count;
  int tests = 0, fails = 0;

  hp_reg3_fifo_m dut (
    .p2_clk(p2_clk), .rst(rst), .two_byte(two_byte), .nmi_en(nmi_en),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .data_available(data_available), .not_full(not_full), .count(count),
    .nmi_req(nmi_req), .overflow(overflow), .underflow(underflow)
  );

  always #5 p2_clk = ~p2_clk;

  task automatic step();
    @(posedge p2_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; step(); wr_en = 1'b0;
  endtask

  task automatic rd();
    rd_en = 1'b1; step(); rd_en = 1'b0;
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    chk("rst_count", 8'(count), 8'd0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_not_full", 8'(not_full), 8'd1);
    chk("rst_da", 8'(data_available), 8'd0);
    chk("rst_flags", {5'd0, overflow, underflow, nmi_req}, 8'd0);
    // 1-byte mode
    wr(8'hA5);
    chk("m1_count", 8'(count), 8'd1);
    chk("m1_da", 8'(data_available), 8'd1);
    chk("m1_not_full", 8'(not_full), 8'd0);
    wr(8'h5A);
    chk("m1_ovf", 8'(overflow), 8'd1);
    chk("m1_ovf_count", 8'(count), 8'd1);
    rd();
    chk("m1_rd", rd_data, 8'hA5);
    chk("m1_rd_count", 8'(count), 8'd0);
    rd();
    chk("unf_flag", 8'(underflow), 8'd1);
    chk("unf_rd_data", rd_data, 8'hA5);
    chk("unf_count", 8'(count), 8'd0);
    // 2-byte mode with NMI
    two_byte = 1'b1; step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("m2_rst_flags", {6'd0, overflow, underflow}, 8'd0);
    nmi_en = 1'b1;
    wr(8'h11);
    chk("m2_da_half", 8'(data_available), 8'd0);
    chk("m2_nmi_half", 8'(nmi_req), 8'd0);
    chk("m2_count1", 8'(count), 8'd1);
    wr(8'h22);
    chk("m2_count2", 8'(count), 8'd2);
    chk("m2_da_full", 8'(data_available), 8'd1);
    chk("m2_nmi_full", 8'(nmi_req), 8'd1);
    rd();
    chk("m2_rd1", rd_data, 8'h11);
    chk("m2_da_after1", 8'(data_available), 8'd0);
    chk("m2_nmi_after1", 8'(nmi_req), 8'd0);
    rd();
    chk("m2_rd2", rd_data, 8'h22);
    chk("m2_count0", 8'(count), 8'd0);
    // simultaneous strobes
    wr(8'h33);
    wr_en = 1'b1; wr_data = 8'h44; rd_en = 1'b1; step(); wr_en = 1'b0; rd_en = 1'b0;
    chk("sim1_rd", rd_data, 8'h33);
    chk("sim1_count", 8'(count), 8'd1);
    chk("sim1_flags", {6'd0, overflow, underflow}, 8'd0);
    wr(8'h55);
    chk("sim2_pre_count", 8'(count), 8'd2);
    wr_en = 1'b1; wr_data = 8'h66; rd_en = 1'b1; step(); wr_en = 1'b0; rd_en = 1'b0;
    chk("sim2_rd", rd_data, 8'h44);
    chk("sim2_count", 8'(count), 8'd1);
    chk("sim2_ovf", 8'(overflow), 8'd1);
    // mode change flush with strobes ignored
    wr(8'h77);
    chk("fl_pre_count", 8'(count), 8'd2);
    two_byte = 1'b0; wr_en = 1'b1; wr_data = 8'h88; rd_en = 1'b1; step(); wr_en = 1'b0; rd_en = 1'b0;
    chk("fl_count", 8'(count), 8'd0);
    chk("fl_unf", 8'(underflow), 8'd0);
    chk("fl_rd_data", rd_data, 8'h44);
    step();
    chk("fl_not_full", 8'(not_full), 8'd1);
    chk("fl_da", 8'(data_available), 8'd0);
    wr(8'h99);
    chk("fl_m1_count", 8'(count), 8'd1);
    chk("fl_m1_da", 8'(data_available), 8'd1);
    // reset while full in 2-byte mode
    two_byte = 1'b1; step();
    wr(8'hAA); wr(8'hBB);
    chk("rs_pre_count", 8'(count), 8'd2);
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hCC; step(); wr_en = 1'b0; rst = 1'b0;
    chk("rs_count", 8'(count), 8'd0);
    chk("rs_rd_data", rd_data, 8'h00);
    chk("rs_flags", {5'd0, overflow, underflow, nmi_req}, 8'd0);
    chk("rs_not_full", 8'(not_full), 8'd1);
    chk("rs_da", 8'(data_available), 8'd0);
    rd();
    chk("rs_unf", 8'(underflow), 8'd1);
    chk("rs_rd_hidden", rd_data, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
